// File: rtl/lpif_txrx_x16_asym2_half_master_gearbox.sv
// Master-side 2:1 gearbox for the x16 asym2 half-rate LPIF link.
// TX packs pairs of downstream beats into 562-bit words; RX splits 562-bit
// words back into two sequential upstream beats. Both paths share clk_wr.
module lpif_txrx_x16_asym2_half_master_gearbox #(
  parameter int BEAT_W   = 281,
  parameter bit DROP_PAD = 1'b1
) (
  input  logic                  clk_wr,
  input  logic                  rst_wr_n,
  input  logic [3:0]            dstrm_state,
  input  logic [1:0]            dstrm_protid,
  input  logic [255:0]          dstrm_data,
  input  logic                  dstrm_dvalid,
  input  logic [15:0]           dstrm_crc,
  input  logic                  dstrm_crc_valid,
  input  logic                  dstrm_valid,
  input  logic                  dstrm_beat_vld,
  output logic                  dstrm_beat_rdy,
  input  logic                  dstrm_flush,
  output logic [2*BEAT_W-1:0]   txfifo_downstream_data,
  output logic                  txfifo_downstream_push,
  input  logic                  txfifo_downstream_full,
  input  logic [2*BEAT_W-1:0]   rxfifo_upstream_data,
  input  logic                  rxfifo_upstream_empty,
  output logic                  rxfifo_upstream_pop,
  output logic [3:0]            ustrm_state,
  output logic [1:0]            ustrm_protid,
  output logic [255:0]          ustrm_data,
  output logic                  ustrm_dvalid,
  output logic [15:0]           ustrm_crc,
  output logic                  ustrm_crc_valid,
  output logic                  ustrm_valid,
  output logic                  ustrm_beat_vld,
  input  logic                  ustrm_beat_rdy,
  output logic [15:0]           pad_cnt
);

  localparam int WORD_W = 2 * BEAT_W;

  typedef enum logic [1:0] {RX_EMPTY, RX_LO, RX_HI} rx_state_e;

  // TX state
  logic                tx_phase_q, tx_phase_d;
  logic [BEAT_W-1:0]   lo_q, lo_d;
  logic [WORD_W-1:0]   out_q, out_d;
  logic                out_vld_q, out_vld_d;
  logic                flush_pend_q, flush_pend_d;
  logic [BEAT_W-1:0]   dstrm_beat;
  logic                tx_rdy, tx_push, tx_accept, flush_req, flush_do;

  // RX state
  rx_state_e           rx_state_q, rx_state_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic [BEAT_W-1:0]   ubeat_q, ubeat_d;
  logic                uvld_q, uvld_d;
  logic                rx_exit, rx_take, rx_drop;

  // Shared pad counter
  logic [15:0]         pad_q, pad_d;
  logic [16:0]         pad_sum;

  // TX: handshake, packing, flush and output-register management
  always_comb begin
    dstrm_beat = {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid,
                  dstrm_data, dstrm_protid, dstrm_state};
    tx_rdy     = !out_vld_q || !txfifo_downstream_full;
    tx_push    = out_vld_q && !txfifo_downstream_full;
    tx_accept  = dstrm_beat_vld && tx_rdy;
    // A flush only matters with a half word held; a beat completing the word wins.
    flush_req  = (dstrm_flush || flush_pend_q) && tx_phase_q && !tx_accept;
    flush_do   = flush_req && tx_rdy;

    tx_phase_d   = tx_phase_q;
    lo_d         = lo_q;
    out_d        = out_q;
    out_vld_d    = out_vld_q;
    flush_pend_d = flush_req && !flush_do;

    if (tx_push) begin
      out_d     = '0;
      out_vld_d = 1'b0;
    end
    if (tx_accept) begin
      if (tx_phase_q) begin
        out_d      = {dstrm_beat, lo_q};
        out_vld_d  = 1'b1;
        tx_phase_d = 1'b0;
      end else begin
        lo_d       = dstrm_beat;
        tx_phase_d = 1'b1;
      end
    end else if (flush_do) begin
      out_d      = {{BEAT_W{1'b0}}, lo_q};
      out_vld_d  = 1'b1;
      tx_phase_d = 1'b0;
    end

    dstrm_beat_rdy         = tx_rdy && rst_wr_n;
    txfifo_downstream_push = tx_push;
    txfifo_downstream_data = out_q;
  end

  // RX: EMPTY/LO/HI sequencing, capture-on-pop and registered beat outputs
  always_comb begin
    rx_state_d = rx_state_q;
    hold_d     = hold_q;
    ubeat_d    = ubeat_q;
    uvld_d     = uvld_q;
    rx_exit    = 1'b0;
    rx_drop    = 1'b0;

    case (rx_state_q)
      RX_EMPTY: ;
      RX_LO: begin
        if (ustrm_beat_rdy) begin
          if (DROP_PAD && !hold_q[WORD_W-1]) begin
            rx_drop = 1'b1;
            rx_exit = 1'b1;
          end else begin
            rx_state_d = RX_HI;
            ubeat_d    = hold_q[WORD_W-1:BEAT_W];
          end
        end
      end
      RX_HI: begin
        if (ustrm_beat_rdy) begin
          rx_exit = 1'b1;
        end
      end
      default: rx_state_d = RX_EMPTY;
    endcase

    // Leaving HI (or a dropped LO) chains straight into the next word if present.
    rx_take = !rxfifo_upstream_empty && (rx_exit || (rx_state_q == RX_EMPTY));
    if (rx_take) begin
      hold_d     = rxfifo_upstream_data;
      ubeat_d    = rxfifo_upstream_data[BEAT_W-1:0];
      uvld_d     = 1'b1;
      rx_state_d = RX_LO;
    end else if (rx_exit) begin
      uvld_d     = 1'b0;
      rx_state_d = RX_EMPTY;
    end

    rxfifo_upstream_pop = rx_take && rst_wr_n;
    ustrm_beat_vld      = uvld_q;
    ustrm_state         = ubeat_q[3:0];
    ustrm_protid        = ubeat_q[5:4];
    ustrm_data          = ubeat_q[261:6];
    ustrm_dvalid        = ubeat_q[262];
    ustrm_crc           = ubeat_q[278:263];
    ustrm_crc_valid     = ubeat_q[279];
    ustrm_valid         = ubeat_q[280];
  end

  // Pad counter: TX flush and RX drop may both count in one cycle; saturates
  always_comb begin
    pad_sum = {1'b0, pad_q} + 17'(flush_do) + 17'(rx_drop);
    pad_d   = pad_sum[16] ? '1 : pad_sum[15:0];
    pad_cnt = pad_q;
  end

  // State registers for both paths
  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      tx_phase_q   <= 1'b0;
      lo_q         <= '0;
      out_q        <= '0;
      out_vld_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      rx_state_q   <= RX_EMPTY;
      hold_q       <= '0;
      ubeat_q      <= '0;
      uvld_q       <= 1'b0;
      pad_q        <= '0;
    end else begin
      tx_phase_q   <= tx_phase_d;
      lo_q         <= lo_d;
      out_q        <= out_d;
      out_vld_q    <= out_vld_d;
      flush_pend_q <= flush_pend_d;
      rx_state_q   <= rx_state_d;
      hold_q       <= hold_d;
      ubeat_q      <= ubeat_d;
      uvld_q       <= uvld_d;
      pad_q        <= pad_d;
    end
  end

endmodule

// File: tb/tb_lpif_txrx_x16_asym2_half_master_gearbox.sv
// Bench for the LPIF x16 asym2 master gearbox: directed TX vector table,
// directed RX/reset sequences, and randomized traffic against a queue model.
module tb_lpif_txrx_x16_asym2_half_master_gearbox;

  localparam bit DP = 1'b1;

  logic         clk = 1'b0;
  logic         rst_wr_n = 1'b0;
  logic [3:0]   dstrm_state;
  logic [1:0]   dstrm_protid;
  logic [255:0] dstrm_data;
  logic         dstrm_dvalid, dstrm_crc_valid, dstrm_valid;
  logic [15:0]  dstrm_crc;
  logic         dstrm_beat_vld, dstrm_flush, tx_full;
  logic         dstrm_beat_rdy, tx_push, rx_pop;
  logic [561:0] tx_data, rx_data;
  logic         rx_empty;
  logic [3:0]   u_state;
  logic [1:0]   u_protid;
  logic [255:0] u_data;
  logic         u_dvalid, u_crc_valid, u_valid, u_vld, u_rdy;
  logic [15:0]  u_crc, pad_cnt;

  logic         d0_rdy, d0_push, rx0_pop, rx0_empty;
  logic [561:0] d0_tx_data, rx0_data;
  logic [3:0]   u0_state;
  logic [1:0]   u0_protid;
  logic [255:0] u0_data;
  logic         u0_dvalid, u0_crc_valid, u0_valid, u0_vld, u0_rdy;
  logic [15:0]  u0_crc, pad0;

  logic [280:0] ubeat, u0beat;
  assign ubeat  = {u_valid, u_crc_valid, u_crc, u_dvalid, u_data, u_protid, u_state};
  assign u0beat = {u0_valid, u0_crc_valid, u0_crc, u0_dvalid, u0_data, u0_protid, u0_state};

  always #5 clk = ~clk;

  lpif_txrx_x16_asym2_half_master_gearbox #(.BEAT_W(281), .DROP_PAD(DP)) dut (
    .clk_wr(clk), .rst_wr_n(rst_wr_n),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .dstrm_beat_vld(dstrm_beat_vld), .dstrm_beat_rdy(dstrm_beat_rdy),
    .dstrm_flush(dstrm_flush), .txfifo_downstream_data(tx_data),
    .txfifo_downstream_push(tx_push), .txfifo_downstream_full(tx_full),
    .rxfifo_upstream_data(rx_data), .rxfifo_upstream_empty(rx_empty),
    .rxfifo_upstream_pop(rx_pop),
    .ustrm_state(u_state), .ustrm_protid(u_protid), .ustrm_data(u_data),
    .ustrm_dvalid(u_dvalid), .ustrm_crc(u_crc), .ustrm_crc_valid(u_crc_valid),
    .ustrm_valid(u_valid), .ustrm_beat_vld(u_vld), .ustrm_beat_rdy(u_rdy),
    .pad_cnt(pad_cnt)
  );

  lpif_txrx_x16_asym2_half_master_gearbox #(.BEAT_W(281), .DROP_PAD(1'b0)) dut0 (
    .clk_wr(clk), .rst_wr_n(rst_wr_n),
    .dstrm_state(dstrm_state), .dstrm_protid(dstrm_protid), .dstrm_data(dstrm_data),
    .dstrm_dvalid(dstrm_dvalid), .dstrm_crc(dstrm_crc), .dstrm_crc_valid(dstrm_crc_valid),
    .dstrm_valid(dstrm_valid), .dstrm_beat_vld(dstrm_beat_vld), .dstrm_beat_rdy(d0_rdy),
    .dstrm_flush(dstrm_flush), .txfifo_downstream_data(d0_tx_data),
    .txfifo_downstream_push(d0_push), .txfifo_downstream_full(tx_full),
    .rxfifo_upstream_data(rx0_data), .rxfifo_upstream_empty(rx0_empty),
    .rxfifo_upstream_pop(rx0_pop),
    .ustrm_state(u0_state), .ustrm_protid(u0_protid), .ustrm_data(u0_data),
    .ustrm_dvalid(u0_dvalid), .ustrm_crc(u0_crc), .ustrm_crc_valid(u0_crc_valid),
    .ustrm_valid(u0_valid), .ustrm_beat_vld(u0_vld), .ustrm_beat_rdy(u0_rdy),
    .pad_cnt(pad0)
  );

  typedef struct {
    bit          vld;
    logic [7:0]  d;
    bit          fl;
    bit          full;
    bit          e_rdy;
    bit          e_push;
    logic [7:0]  e_lo;   // nonzero: output word expected to hold this pair
    logic [7:0]  e_hi;   // 0 with e_lo nonzero: padded upper half
    int unsigned e_pad;
  } vec_t;

  typedef struct {
    logic [280:0] b;
    bit           drop;  // consuming this beat drops the following pad beat
  } rxb_t;

  int unsigned  n_checks = 0;
  int unsigned  n_errors = 0;
  int unsigned  m_pad;
  vec_t         tbl[16];
  logic [561:0] txq[$];
  logic [561:0] rxf[$];
  logic [561:0] rx0f[$];
  rxb_t         rxs[$];
  logic [280:0] half, cur_beat;
  bit           half_v, fpend_m;
  logic [561:0] w0, w1, wp, wr, wexp;
  bit           ep[6], ev[6];
  logic [280:0] eb[6];

  task automatic chk(input string nm, input logic [561:0] act, input logic [561:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [280:0] tbeat(input logic [7:0] d);
    return {1'b1, 1'b0, 16'h0, 1'b1, 256'(d), 2'b00, 4'h0};
  endfunction

  function automatic logic [280:0] rand_beat();
    logic [287:0] t;
    for (int k = 0; k < 9; k++) t[k*32 +: 32] = $urandom();
    return t[280:0];
  endfunction

  function automatic logic [561:0] rand_word();
    logic [575:0] t;
    for (int k = 0; k < 18; k++) t[k*32 +: 32] = $urandom();
    return t[561:0];
  endfunction

  task automatic set_beat(input logic [280:0] b);
    cur_beat = b;
    {dstrm_valid, dstrm_crc_valid, dstrm_crc, dstrm_dvalid, dstrm_data, dstrm_protid, dstrm_state} = b;
  endtask

  task automatic drive_rx();
    rx_empty = (rxf.size() == 0);
    rx_data  = rx_empty ? '0 : rxf[0];
  endtask

  task automatic drive_rx0();
    rx0_empty = (rx0f.size() == 0);
    rx0_data  = rx0_empty ? '0 : rx0f[0];
  endtask

  task automatic pad_inc();
    if (m_pad != 65535) m_pad++;
  endtask

  // Reference model step: word/beat streams as queues, sampled between edges.
  task automatic model_step();
    bit e_rdy, e_push, acc, freq, dr;
    logic [561:0] w;
    e_rdy  = (txq.size() == 0) || !tx_full;
    e_push = (txq.size() != 0) && !tx_full;
    chk("rnd_rdy", dstrm_beat_rdy, e_rdy);
    chk("rnd_push", tx_push, e_push);
    if (tx_push && e_push) chk("rnd_word", tx_data, txq[0]);
    chk("rnd_pad", pad_cnt, m_pad);
    if (u_vld) begin
      chk("rnd_beat_queued", rxs.size() != 0, 1'b1);
      if (rxs.size() != 0) begin
        chk("rnd_beat", ubeat, rxs[0].b);
        if (u_rdy) begin
          if (rxs[0].drop) pad_inc();
          void'(rxs.pop_front());
        end
      end
    end
    if (rx_pop) begin
      chk("rnd_pop_nonempty", rxf.size() != 0, 1'b1);
      if (rxf.size() != 0) begin
        w  = rxf.pop_front();
        dr = DP && !w[561];
        rxs.push_back('{w[280:0], dr});
        if (!dr) rxs.push_back('{w[561:281], 1'b0});
      end
    end
    acc = dstrm_beat_vld && e_rdy;
    if (e_push) void'(txq.pop_front());
    freq = (dstrm_flush || fpend_m) && half_v && !acc;
    if (acc) begin
      if (half_v) begin
        txq.push_back({cur_beat, half});
        half_v = 1'b0;
      end else begin
        half   = cur_beat;
        half_v = 1'b1;
      end
      fpend_m = 1'b0;
    end else if (freq && e_rdy) begin
      txq.push_back({281'b0, half});
      half_v  = 1'b0;
      fpend_m = 1'b0;
      pad_inc();
    end else begin
      fpend_m = freq;
    end
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1, 8'd1, 0, 0, 1, 0, 8'd0, 8'd0, 0};
    tbl[1]  = '{1, 8'd2, 0, 0, 1, 0, 8'd0, 8'd0, 0};
    tbl[2]  = '{0, 8'd0, 0, 0, 1, 1, 8'd1, 8'd2, 0};
    tbl[3]  = '{1, 8'd3, 0, 0, 1, 0, 8'd0, 8'd0, 0};
    tbl[4]  = '{1, 8'd4, 0, 1, 1, 0, 8'd0, 8'd0, 0};
    tbl[5]  = '{1, 8'd5, 0, 1, 0, 0, 8'd3, 8'd4, 0};
    tbl[6]  = '{1, 8'd5, 0, 1, 0, 0, 8'd3, 8'd4, 0};
    tbl[7]  = '{1, 8'd5, 0, 0, 1, 1, 8'd3, 8'd4, 0};
    tbl[8]  = '{0, 8'd0, 1, 0, 1, 0, 8'd0, 8'd0, 0};
    tbl[9]  = '{0, 8'd0, 0, 0, 1, 1, 8'd5, 8'd0, 1};
    tbl[10] = '{0, 8'd0, 1, 0, 1, 0, 8'd0, 8'd0, 1};
    tbl[11] = '{0, 8'd0, 0, 0, 1, 0, 8'd0, 8'd0, 1};
    tbl[12] = '{1, 8'd6, 0, 0, 1, 0, 8'd0, 8'd0, 1};
    tbl[13] = '{1, 8'd7, 1, 0, 1, 0, 8'd0, 8'd0, 1};
    tbl[14] = '{0, 8'd0, 0, 0, 1, 1, 8'd6, 8'd7, 1};
    tbl[15] = '{0, 8'd0, 0, 0, 1, 0, 8'd0, 8'd0, 1};

    // Reset state, with FIFO non-empty and TX FIFO not full
    dstrm_beat_vld = 0; dstrm_flush = 0; tx_full = 0;
    set_beat(rand_beat());
    rx_data = rand_word(); rx_empty = 0;
    rx0_data = rand_word(); rx0_empty = 0;
    u_rdy = 0; u0_rdy = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", dstrm_beat_rdy, 0);
    chk("rst_push", tx_push, 0);
    chk("rst_pop", rx_pop, 0);
    chk("rst_uvld", u_vld, 0);
    chk("rst_pad", pad_cnt, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_ubeat", ubeat, 0);
    chk("rst_pop0", rx0_pop, 0);
    @(negedge clk);
    rx_empty = 1; rx0_empty = 1; rx_data = '0; rx0_data = '0;
    rst_wr_n = 1;

    // TX vector table: pair, backpressure, flush, no-op flush, flush+accept
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dstrm_beat_vld = tbl[i].vld;
      set_beat(tbeat(tbl[i].d));
      dstrm_flush = tbl[i].fl;
      tx_full = tbl[i].full;
      #1;
      chk($sformatf("tbl%0d_rdy", i), dstrm_beat_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_push", i), tx_push, tbl[i].e_push);
      chk($sformatf("tbl%0d_pad", i), pad_cnt, tbl[i].e_pad);
      chk($sformatf("tbl%0d_rdy0", i), d0_rdy, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_push0", i), d0_push, tbl[i].e_push);
      if (tbl[i].e_lo != 0) begin
        wexp = {(tbl[i].e_hi == 0) ? 281'b0 : tbeat(tbl[i].e_hi), tbeat(tbl[i].e_lo)};
        chk($sformatf("tbl%0d_word", i), tx_data, wexp);
        chk($sformatf("tbl%0d_word0", i), d0_tx_data, wexp);
      end
    end
    @(negedge clk);
    dstrm_beat_vld = 0; dstrm_flush = 0; tx_full = 0;

    // RX split: two words, sink always ready -> lo0 hi0 lo1 hi1 back to back
    w0 = rand_word(); w0[561] = 1'b1;
    w1 = rand_word(); w1[561] = 1'b1;
    rxf = {w0, w1};
    u_rdy = 1;
    ep = '{1, 0, 1, 0, 0, 0};
    ev = '{0, 1, 1, 1, 1, 0};
    eb = '{281'b0, w0[280:0], w0[561:281], w1[280:0], w1[561:281], 281'b0};
    for (int t = 0; t < 6; t++) begin
      if (t != 0) @(negedge clk);
      drive_rx();
      #1;
      chk($sformatf("split%0d_pop", t), rx_pop, ep[t]);
      chk($sformatf("split%0d_vld", t), u_vld, ev[t]);
      if (ev[t]) chk($sformatf("split%0d_beat", t), ubeat, eb[t]);
      if (rx_pop && rxf.size() != 0) void'(rxf.pop_front());
    end

    // RX pad beat: dropped with DROP_PAD=1, presented with DROP_PAD=0
    wp = rand_word(); wp[561] = 1'b0; wp[280] = 1'b1;
    rxf = {wp}; rx0f = {wp};
    u_rdy = 1; u0_rdy = 1;
    ep = '{1, 0, 0, 0, 0, 0};
    ev = '{0, 1, 0, 0, 0, 0};
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      drive_rx(); drive_rx0();
      #1;
      chk($sformatf("drop%0d_pop", t), rx_pop, ep[t]);
      chk($sformatf("drop%0d_vld", t), u_vld, ev[t]);
      chk($sformatf("drop%0d_pad", t), pad_cnt, (t >= 2) ? 2 : 1);
      chk($sformatf("keep%0d_pop", t), rx0_pop, ep[t]);
      chk($sformatf("keep%0d_vld", t), u0_vld, (t == 1 || t == 2));
      chk($sformatf("keep%0d_pad", t), pad0, 1);
      if (t == 1) chk("drop_lo_beat", ubeat, wp[280:0]);
      if (t == 1) chk("keep_lo_beat", u0beat, wp[280:0]);
      if (t == 2) chk("keep_hi_beat", u0beat, wp[561:281]);
      if (rx_pop && rxf.size() != 0) void'(rxf.pop_front());
      if (rx0_pop && rx0f.size() != 0) void'(rx0f.pop_front());
    end
    @(negedge clk);
    u0_rdy = 0; rx0f.delete(); drive_rx0();

    // Randomized concurrent TX/RX traffic against the queue model
    m_pad = 2; half_v = 0; fpend_m = 0;
    txq.delete(); rxs.delete(); rxf.delete();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      dstrm_beat_vld = ($urandom_range(3) != 0);
      set_beat(rand_beat());
      dstrm_flush = ($urandom_range(7) == 0);
      tx_full = ($urandom_range(2) == 0);
      if (rxf.size() < 3 && $urandom_range(1) == 1) rxf.push_back(rand_word());
      u_rdy = ($urandom_range(3) != 0);
      drive_rx();
      #1;
      model_step();
    end
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      dstrm_beat_vld = 0; dstrm_flush = 1; tx_full = 0; u_rdy = 1;
      drive_rx();
      #1;
      model_step();
    end
    chk("drain_tx", txq.size(), 0);
    chk("drain_rx_beats", rxs.size(), 0);
    chk("drain_rxfifo", rxf.size(), 0);

    // Async reset with TX half word held and RX presenting beat1
    @(negedge clk);
    dstrm_flush = 0; dstrm_beat_vld = 1; set_beat(tbeat(8'hA1)); tx_full = 0;
    wr = rand_word(); wr[561] = 1'b1;
    rxf = {wr}; u_rdy = 0;
    drive_rx();
    #1;
    chk("rstseq_pop", rx_pop, 1);
    if (rx_pop) void'(rxf.pop_front());
    @(negedge clk);
    dstrm_beat_vld = 0; u_rdy = 1; drive_rx();
    @(negedge clk);
    u_rdy = 0; rxf.push_back(rand_word()); drive_rx();
    #1;
    chk("rstseq_hi_vld", u_vld, 1);
    chk("rstseq_hi_beat", ubeat, wr[561:281]);
    chk("rstseq_hi_nopop", rx_pop, 0);
    @(posedge clk);
    #3;
    rst_wr_n = 0;
    #1;
    chk("arst_rdy", dstrm_beat_rdy, 0);
    chk("arst_push", tx_push, 0);
    chk("arst_pop", rx_pop, 0);
    chk("arst_uvld", u_vld, 0);
    chk("arst_ubeat", ubeat, 0);
    chk("arst_pad", pad_cnt, 0);
    chk("arst_txdata", tx_data, 0);
    repeat (2) @(negedge clk);
    rxf.delete(); drive_rx(); u_rdy = 1;
    rst_wr_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("post%0d_push", i), tx_push, 0);
      chk($sformatf("post%0d_uvld", i), u_vld, 0);
    end
    @(negedge clk);
    dstrm_beat_vld = 1; set_beat(tbeat(8'hB2));
    #1;
    chk("post_rdy", dstrm_beat_rdy, 1);
    @(negedge clk);
    dstrm_beat_vld = 0; dstrm_flush = 1;
    #1;
    chk("post_flush_nopush", tx_push, 0);
    @(negedge clk);
    dstrm_flush = 0;
    #1;
    chk("post_push", tx_push, 1);
    chk("post_word", tx_data, {281'b0, tbeat(8'hB2)});
    chk("post_pad", pad_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lpif_txrx_x16_asym2_half_master_gearbox.md
Name: lpif_txrx_x16_asym2_half_master_gearbox

Overview:
- Master-side 2:1 gearbox for the x16 asym2 half-rate LPIF link.
- TX path: packs consecutive single-beat downstream LPIF beats into 562-bit logic-link words for the TX FIFO.
- RX path: splits 562-bit upstream words from the RX FIFO into two sequential beats.
- Word layout: beat0 in bits [0 +: 281], beat1 in [281 +: 281]. Per beat: state[0+:4], protid[4+:2], data[6+:256], dvalid[262], crc[263+:16], crc_valid[279], valid[280].

Parameters:
- BEAT_W, 281, packed beat width; fixed, not user-tunable.
- DROP_PAD, 1, when 1 the RX path skips a beat1 whose valid bit (word bit 561) is 0.

Ports:
- clk_wr  in  1  single clock for both paths.
- rst_wr_n  in  1  asynchronous active-low reset.
- dstrm_state/protid/data/dvalid/crc/crc_valid/valid  in  4/2/256/1/16/1/1  downstream beat fields.
- dstrm_beat_vld  in  1  downstream beat offered.
- dstrm_beat_rdy  out  1  downstream beat accepted when vld&rdy.
- dstrm_flush  in  1  emit a pending half word, padding beat1.
- txfifo_downstream_data  out  562  packed word.
- txfifo_downstream_push  out  1  push strobe.
- txfifo_downstream_full  in  1  TX FIFO full.
- rxfifo_upstream_data  in  562  show-ahead word, valid while empty=0.
- rxfifo_upstream_empty  in  1  RX FIFO empty.
- rxfifo_upstream_pop  out  1  consume the current word.
- ustrm_state/protid/data/dvalid/crc/crc_valid/valid  out  4/2/256/1/16/1/1  upstream beat fields.
- ustrm_beat_vld  out  1  upstream beat presented.
- ustrm_beat_rdy  in  1  upstream sink ready.
- pad_cnt  out  16  saturating count of padded words emitted plus pad beats dropped.

Behaviour:
- Reset: all outputs 0; tx_phase=0; tx_out_vld=0; RX state EMPTY; pad_cnt=0. Reset mid-operation discards partial and held words without emitting them.
- TX packing:
  - dstrm_beat_rdy = !tx_out_vld | !txfifo_downstream_full.
  - On accept with phase 0: store the beat in lo_reg; phase becomes 1.
  - On accept with phase 1: load {beat, lo_reg} into the output register; set tx_out_vld; phase becomes 0.
- TX push:
  - txfifo_downstream_push = tx_out_vld & !txfifo_downstream_full, combinational from registered state.
  - The output register clears on push, unless a new word loads in the same cycle (back-to-back, one word per 2 beats at full throughput).
  - TX latency: beat1 accepted in cycle N gives push in N+1 if FIFO not full.
- TX flush:
  - dstrm_flush with phase 1 and no beat accept that cycle loads {281'b0, lo_reg}; pad_cnt increments.
  - Flush is applied only if the output register is free or being pushed that cycle; otherwise it is held pending until then.
  - Flush with phase 0 is a no-op.
  - Flush and beat accept in the same cycle: the beat completes the word normally, and the flush is ignored.
- RX state machine (EMPTY, LO, HI):
  - EMPTY: when !empty, capture word into hold register, pop=1, go to LO.
  - LO: ustrm_beat_vld=1 with fields from hold[0+:281].
    - On rdy, go to HI.
    - If DROP_PAD and hold[561]=0: drop beat1 (pad_cnt++) and act as the HI-exit below.
  - HI: fields from hold[281+:281]. On rdy:
    - if !empty, capture next word, pop=1, go to LO (no bubble);
    - else go to EMPTY.
  - pop is single-cycle and asserted only on capture. Upstream outputs are registered from hold and are stable while vld&!rdy.
  - ustrm_beat_vld=0 in EMPTY; field outputs hold their last values.
- pad_cnt saturates at 16'hFFFF. Simultaneous TX and RX increments add 2, saturating.
- TX and RX paths are independent; simultaneous activity is legal.

Test Plan:
- TX pair: beats A (data=256'h1, valid=1) then B (data=256'h2) on consecutive cycles, FIFO not full -> one push; word[6+:256]=1, word[287+:256]=2, word[280]=word[561]=1.
- TX backpressure: full=1 after pair loaded -> push=0, dstrm_beat_rdy=0, word stable; full=0 -> push on that cycle and rdy=1.
- TX flush: single beat C then flush -> word lo=C, bits[561:281]=0, pad_cnt=1. Flush with phase 0 -> no push.
- RX split: two words in FIFO, ustrm_beat_rdy=1 -> 4 beats on consecutive cycles in order lo0, hi0, lo1, hi1; pop pulses on the cycles entering LO.
- RX pad drop: word with bit561=0, DROP_PAD=1 -> only one beat presented, pad_cnt=1; with DROP_PAD=0 -> 2 beats.
- Async reset asserted mid-RX (state HI) and mid-TX (phase 1) -> outputs 0 immediately; after release, no stale beat or push appears.
